// File: rtl/wb_stage.sv
// -----------------------------------------------------------------------------
// wb_stage -- write-back stage of the 5-stage pipelined MIPS CPU.
//
// Holds the MEM/WB pipeline register and produces:
//   * the register-file write port (wb_wreg / wb_destR / wb_data / rf_we),
//   * the forwarding source for the execute stage (same registered fields),
//   * a retired-instruction counter and a halt state machine for the lab
//     display/debug logic.
//
// Parameters
//   HALT_TYPE  MEM_ins_type code treated as a halt instruction
//   CNT_W      width of the retired-instruction counter (saturating)
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   stall, flush    hold the MEM/WB register / load a bubble (flush wins)
//   mem_*           memory-stage register-write controls, load data, ALU
//                   result and destination register
//   MEM_ins_type    instruction type tag entering the stage
//   MEM_ins_number  instruction sequence tag entering the stage
//   wb_wreg         registered write enable qualified by valid and halt
//   wb_destR        registered destination register
//   wb_data         m2reg ? load data : ALU result (from registered fields)
//   rf_we           register-file write strobe, never asserted for $0
//   WB_ins_type     registered type tag
//   WB_ins_number   registered sequence tag
//   wb_valid        MEM/WB register holds a real instruction
//   halted          halt state machine is in HALTED
//   retire_count    number of retired instructions (saturates at all-ones)
//
// Every output is taken from registers, optionally through a small amount of
// combinational logic on those registers; no input reaches an output
// combinationally.
// -----------------------------------------------------------------------------
module wb_stage #(
  parameter logic [3:0] HALT_TYPE = 4'hF,
  parameter int         CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             mem_wreg,
  input  logic             mem_m2reg,
  input  logic [31:0]      mem_mdata,
  input  logic [31:0]      mem_aluR,
  input  logic [4:0]       mem_destR,
  input  logic [3:0]       MEM_ins_type,
  input  logic [3:0]       MEM_ins_number,
  output logic             wb_wreg,
  output logic [4:0]       wb_destR,
  output logic [31:0]      wb_data,
  output logic             rf_we,
  output logic [3:0]       WB_ins_type,
  output logic [3:0]       WB_ins_number,
  output logic             wb_valid,
  output logic             halted,
  output logic [CNT_W-1:0] retire_count
);

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e             state_q,  state_d;
  logic               valid_q,  valid_d;
  logic               wreg_q,   wreg_d;
  logic               m2reg_q,  m2reg_d;
  logic [31:0]        mdata_q,  mdata_d;
  logic [31:0]        alur_q,   alur_d;
  logic [4:0]         destr_q,  destr_d;
  logic [3:0]         type_q,   type_d;
  logic [3:0]         number_q, number_d;
  logic [CNT_W-1:0]   count_q,  count_d;

  logic               is_halted;
  logic               retire;

  assign is_halted = (state_q == ST_HALTED);

  // ---------------------------------------------------------------------------
  // Next-state logic. Update priority (reset is applied in the flop block):
  // halted > flush > stall > load.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before any branch so no path through
    // this block leaves a variable unassigned, which would infer a latch.
    state_d  = state_q;
    valid_d  = valid_q;
    wreg_d   = wreg_q;
    m2reg_d  = m2reg_q;
    mdata_d  = mdata_q;
    alur_d   = alur_q;
    destr_d  = destr_q;
    type_d   = type_q;
    number_d = number_q;

    if (is_halted) begin
      // The halt instruction sitting in WB retires on the first HALTED edge;
      // afterwards the register is frozen with nothing valid in it.
      valid_d = 1'b0;
      wreg_d  = 1'b0;
    end else if (flush) begin
      valid_d  = 1'b0;
      wreg_d   = 1'b0;
      m2reg_d  = 1'b0;
      mdata_d  = '0;
      alur_d   = '0;
      destr_d  = '0;
      type_d   = '0;
      number_d = '0;
    end else if (!stall) begin
      valid_d  = 1'b1;
      wreg_d   = mem_wreg;
      m2reg_d  = mem_m2reg;
      mdata_d  = mem_mdata;
      alur_d   = mem_aluR;
      destr_d  = mem_destR;
      type_d   = MEM_ins_type;
      number_d = MEM_ins_number;
      // A halt is captured so it can be seen in WB, but it never writes.
      if (MEM_ins_type == HALT_TYPE) begin
        wreg_d  = 1'b0;
        state_d = ST_HALTED;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Retire counter: an instruction retires on the edge where it leaves WB,
  // i.e. the register is not holding it. Leaving happens on a normal load, on
  // a flush (which replaces it with a bubble, even under stall), and on the
  // first HALTED edge (the halt instruction itself). Saturates at all-ones.
  // ---------------------------------------------------------------------------
  always_comb begin
    retire  = valid_q & (is_halted | flush | ~stall);
    count_d = count_q;
    if (retire && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: flops are written with non-blocking assignments so every register
  // samples the pre-edge value of the others regardless of statement order.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous and clears the data registers too, so the
    // outputs are fully defined after the first reset edge.
    if (rst) begin
      state_q  <= ST_RUN;
      valid_q  <= 1'b0;
      wreg_q   <= 1'b0;
      m2reg_q  <= 1'b0;
      mdata_q  <= '0;
      alur_q   <= '0;
      destr_q  <= '0;
      type_q   <= '0;
      number_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      wreg_q   <= wreg_d;
      m2reg_q  <= m2reg_d;
      mdata_q  <= mdata_d;
      alur_q   <= alur_d;
      destr_q  <= destr_d;
      type_q   <= type_d;
      number_q <= number_d;
      count_q  <= count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (registered fields only)
  // ---------------------------------------------------------------------------
  assign wb_valid      = valid_q;
  assign wb_wreg       = wreg_q & valid_q;
  assign wb_destR      = destr_q;
  assign wb_data       = m2reg_q ? mdata_q : alur_q;
  // $0 is hard-wired to zero in MIPS; writes to it are dropped here.
  assign rf_we         = wb_wreg & (destr_q != 5'd0);
  assign WB_ins_type   = type_q;
  assign WB_ins_number = number_q;
  assign halted        = is_halted;
  assign retire_count  = count_q;

endmodule

// File: tb/tb_wb_stage.sv
// -----------------------------------------------------------------------------
// tb_wb_stage -- self-checking bench for wb_stage.
//
// Two instances share the same stimulus: one with the default 16-bit retire
// counter and one with a 4-bit counter for the saturation case. A
// transaction-level model tracks what sits in WB, whether the machine is
// halted, and how many instructions have retired (unbounded, saturated only
// when compared). Outputs are compared against it on every falling edge;
// directed steps also check hand-computed literal values.
// -----------------------------------------------------------------------------
module tb_wb_stage;

  localparam logic [3:0] HALT = 4'hF;

  logic        clk = 1'b0;
  logic        rst, stall, flush;
  logic        mem_wreg, mem_m2reg;
  logic [31:0] mem_mdata, mem_aluR;
  logic [4:0]  mem_destR;
  logic [3:0]  MEM_ins_type, MEM_ins_number;

  logic        wb_wreg, rf_we, wb_valid, halted;
  logic [4:0]  wb_destR;
  logic [31:0] wb_data;
  logic [3:0]  WB_ins_type, WB_ins_number;
  logic [15:0] retire_count;

  logic        s_wb_wreg, s_rf_we, s_wb_valid, s_halted;
  logic [4:0]  s_wb_destR;
  logic [31:0] s_wb_data;
  logic [3:0]  s_WB_ins_type, s_WB_ins_number;
  logic [3:0]  s_retire_count;

  always #5 clk = ~clk;

  wb_stage #(.HALT_TYPE(HALT), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg), .mem_mdata(mem_mdata),
    .mem_aluR(mem_aluR), .mem_destR(mem_destR),
    .MEM_ins_type(MEM_ins_type), .MEM_ins_number(MEM_ins_number),
    .wb_wreg(wb_wreg), .wb_destR(wb_destR), .wb_data(wb_data), .rf_we(rf_we),
    .WB_ins_type(WB_ins_type), .WB_ins_number(WB_ins_number),
    .wb_valid(wb_valid), .halted(halted), .retire_count(retire_count)
  );

  wb_stage #(.HALT_TYPE(HALT), .CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg), .mem_mdata(mem_mdata),
    .mem_aluR(mem_aluR), .mem_destR(mem_destR),
    .MEM_ins_type(MEM_ins_type), .MEM_ins_number(MEM_ins_number),
    .wb_wreg(s_wb_wreg), .wb_destR(s_wb_destR), .wb_data(s_wb_data), .rf_we(s_rf_we),
    .WB_ins_type(s_WB_ins_type), .WB_ins_number(s_WB_ins_number),
    .wb_valid(s_wb_valid), .halted(s_halted), .retire_count(s_retire_count)
  );

  // ---------------------------------------------------------------------------
  // Check bookkeeping
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Model: the instruction occupying WB, the halt flag, and a retire tally.
  // ---------------------------------------------------------------------------
  typedef struct {
    bit        valid;
    bit        wreg;
    bit        m2reg;
    bit [31:0] mdata;
    bit [31:0] alu;
    bit [4:0]  dest;
    bit [3:0]  typ;
    bit [3:0]  num;
  } slot_t;

  slot_t m_slot;
  bit    m_halted;
  int    m_retired;
  bit    model_ok = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_slot    = '{default: 0};
      m_halted  = 1'b0;
      m_retired = 0;
      model_ok  = 1'b1;
    end else if (model_ok) begin
      // The WB occupant retires whenever it is not being held.
      if (m_slot.valid && (m_halted || flush || !stall)) m_retired++;
      if (m_halted) begin
        m_slot.valid = 1'b0;
        m_slot.wreg  = 1'b0;
      end else if (flush) begin
        m_slot = '{default: 0};
      end else if (!stall) begin
        m_slot = '{valid: 1'b1, wreg: mem_wreg && (MEM_ins_type != HALT),
                   m2reg: mem_m2reg, mdata: mem_mdata, alu: mem_aluR,
                   dest: mem_destR, typ: MEM_ins_type, num: MEM_ins_number};
        if (MEM_ins_type == HALT) m_halted = 1'b1;
      end
    end
  end

  // Compare process: every falling edge once the model has seen a reset.
  always @(negedge clk) begin
    if (model_ok) begin
      logic        e_wreg;
      logic [31:0] e_data;
      e_wreg = m_slot.valid && m_slot.wreg;
      e_data = m_slot.m2reg ? m_slot.mdata : m_slot.alu;
      check("wb_valid",      {31'd0, wb_valid},   {31'd0, m_slot.valid});
      check("wb_wreg",       {31'd0, wb_wreg},    {31'd0, e_wreg});
      check("rf_we",         {31'd0, rf_we},      {31'd0, e_wreg && (m_slot.dest != 0)});
      check("wb_destR",      {27'd0, wb_destR},   {27'd0, m_slot.dest});
      check("wb_data",       wb_data,             e_data);
      check("WB_ins_type",   {28'd0, WB_ins_type},   {28'd0, m_slot.typ});
      check("WB_ins_number", {28'd0, WB_ins_number}, {28'd0, m_slot.num});
      check("halted",        {31'd0, halted},     {31'd0, m_halted});
      check("retire_count",  {16'd0, retire_count},
            (m_retired > 65535) ? 32'd65535 : 32'(m_retired));
      check("retire_count4", {28'd0, s_retire_count},
            (m_retired > 15) ? 32'd15 : 32'(m_retired));
      check("s_wb_data",     s_wb_data,           e_data);
      check("s_halted",      {31'd0, s_halted},   {31'd0, m_halted});
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: inputs change 1 time unit after the rising edge.
  // ---------------------------------------------------------------------------
  task automatic cyc(input logic w, input logic m2, input logic [31:0] md,
                     input logic [31:0] al, input logic [4:0] d,
                     input logic [3:0] t, input logic [3:0] n,
                     input logic st, input logic fl, input logic r);
    mem_wreg = w; mem_m2reg = m2; mem_mdata = md; mem_aluR = al;
    mem_destR = d; MEM_ins_type = t; MEM_ins_number = n;
    stall = st; flush = fl; rst = r;
    @(posedge clk);
    #1;
  endtask

  task automatic bubble();
    cyc(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic reset_cyc();
    cyc(1'b1, 1'b0, 32'h5555_5555, 32'h6666_6666, 5'd7, 4'd2, 4'd9, 1'b0, 1'b0, 1'b1);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    mem_wreg = 1'b0; mem_m2reg = 1'b0; mem_mdata = '0; mem_aluR = '0;
    mem_destR = '0; MEM_ins_type = '0; MEM_ins_number = '0;

    // Reset state
    reset_cyc();
    check("rst wb_valid", {31'd0, wb_valid}, 32'd0);
    check("rst wb_data", wb_data, 32'd0);
    check("rst retire_count", {16'd0, retire_count}, 32'd0);
    check("rst halted", {31'd0, halted}, 32'd0);

    // ALU write, 1-cycle latency
    cyc(1'b1, 1'b0, 32'h0, 32'h0000_1234, 5'd8, 4'd1, 4'd1, 1'b0, 1'b0, 1'b0);
    check("alu wb_wreg", {31'd0, wb_wreg}, 32'd1);
    check("alu rf_we", {31'd0, rf_we}, 32'd1);
    check("alu wb_destR", {27'd0, wb_destR}, 32'd8);
    check("alu wb_data", wb_data, 32'h0000_1234);
    check("alu wb_valid", {31'd0, wb_valid}, 32'd1);
    bubble();
    check("alu retired", {16'd0, retire_count}, 32'd1);

    // Load select, then a write aimed at $0
    cyc(1'b1, 1'b1, 32'hDEAD_BEEF, 32'h10, 5'd9, 4'd2, 4'd2, 1'b0, 1'b0, 1'b0);
    check("load wb_data", wb_data, 32'hDEAD_BEEF);
    check("load rf_we", {31'd0, rf_we}, 32'd1);
    cyc(1'b1, 1'b1, 32'hDEAD_BEEF, 32'h10, 5'd0, 4'd2, 4'd3, 1'b0, 1'b0, 1'b0);
    check("r0 wb_wreg", {31'd0, wb_wreg}, 32'd1);
    check("r0 rf_we", {31'd0, rf_we}, 32'd0);
    bubble();

    // Stall holds A while B waits; stall+flush then yields a bubble
    cyc(1'b1, 1'b0, 32'h0, 32'h0000_000A, 5'd3, 4'd1, 4'd3, 1'b0, 1'b0, 1'b0);
    check("A tag", {28'd0, WB_ins_number}, 32'd3);
    check("A count", {16'd0, retire_count}, 32'd3);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, 32'h0, 32'h0000_000B, 5'd5, 4'd2, 4'd7, 1'b1, 1'b0, 1'b0);
      check("stall tag", {28'd0, WB_ins_number}, 32'd3);
      check("stall data", wb_data, 32'h0000_000A);
      check("stall count", {16'd0, retire_count}, 32'd3);
    end
    cyc(1'b1, 1'b0, 32'h0, 32'h0000_000B, 5'd5, 4'd2, 4'd7, 1'b1, 1'b1, 1'b0);
    check("sf wb_valid", {31'd0, wb_valid}, 32'd0);
    check("sf wb_wreg", {31'd0, wb_wreg}, 32'd0);
    check("sf type", {28'd0, WB_ins_type}, 32'd0);
    check("sf number", {28'd0, WB_ins_number}, 32'd0);
    bubble();

    // Reset in the middle of a stall
    cyc(1'b1, 1'b0, 32'h0, 32'h0000_00C0, 5'd6, 4'd1, 4'd5, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 32'h0, 32'h0000_00C1, 5'd6, 4'd1, 4'd6, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 32'h0, 32'h0000_00C1, 5'd6, 4'd1, 4'd6, 1'b1, 1'b0, 1'b1);
    check("rst-stall wb_valid", {31'd0, wb_valid}, 32'd0);
    check("rst-stall count", {16'd0, retire_count}, 32'd0);

    // Halt: five instructions, the fourth is the halt
    for (int i = 1; i <= 5; i++) begin
      cyc(1'b1, 1'b0, 32'h0, 32'h40 + 32'(i), 5'(i), (i == 4) ? HALT : 4'd1,
          4'(i), 1'b0, 1'b0, 1'b0);
      if (i == 4) begin
        check("halt halted", {31'd0, halted}, 32'd1);
        check("halt wb_wreg", {31'd0, wb_wreg}, 32'd0);
        check("halt wb_valid", {31'd0, wb_valid}, 32'd1);
        check("halt count", {16'd0, retire_count}, 32'd3);
      end
    end
    check("halt retired", {16'd0, retire_count}, 32'd4);
    for (int i = 0; i < 20; i++) begin
      cyc(1'($urandom), 1'($urandom), $urandom, $urandom, 5'($urandom),
          4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 1'b0);
    end
    check("halt frozen count", {16'd0, retire_count}, 32'd4);
    check("halt frozen halted", {31'd0, halted}, 32'd1);
    check("halt frozen number", {28'd0, WB_ins_number}, 32'd4);

    // Reset from HALTED, then a normal load
    reset_cyc();
    check("rst-halt halted", {31'd0, halted}, 32'd0);
    check("rst-halt count", {16'd0, retire_count}, 32'd0);
    check("rst-halt wb_valid", {31'd0, wb_valid}, 32'd0);
    cyc(1'b1, 1'b0, 32'h0, 32'h0000_0777, 5'd12, 4'd1, 4'd1, 1'b0, 1'b0, 1'b0);
    check("post-halt wb_valid", {31'd0, wb_valid}, 32'd1);
    check("post-halt wb_data", wb_data, 32'h0000_0777);

    // Saturation: 20 consecutive instructions into the 4-bit counter
    reset_cyc();
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 1'b0, 32'h0, 32'(i), 5'd1, 4'd1, 4'(i), 1'b0, 1'b0, 1'b0);
    end
    bubble();
    check("sat count4", {28'd0, s_retire_count}, 32'h0000_000F);
    check("sat count16", {16'd0, retire_count}, 32'd20);

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
